elevator_call_scheduler: RTL and testbench

//  Upstream stage of the elevator car controller: turns raw per-floor call buttons into requested_floor.

---
 rtl/elevator_call_scheduler.sv | 165 ++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// Call-button front end for the elevator car controller: synchronises and debounces buttons,
// latches pending calls and picks the next target floor with SCAN ordering.
module elevator_call_scheduler #(
   parameter int NUM_FLOORS      = 6,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] call_btn,
   input  logic [3:0]            current_floor,
   input  logic                  car_idle,
   output logic [3:0]            requested_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  dir_up,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2
   } state_t;

   logic [NUM_FLOORS-1:0] sync1_r;
   logic [NUM_FLOORS-1:0] sync2_r;
   logic [CNT_W-1:0]      cnt_r [NUM_FLOORS];
   logic [NUM_FLOORS-1:0] press_s;
   logic [NUM_FLOORS-1:0] pending_nxt_s;
   logic                  above_s;
   logic                  below_s;
   logic [3:0]            up_tgt_s;
   logic [3:0]            dn_tgt_s;
   state_t                state_r;

   // Two-flop synchroniser followed by a saturating stable-high counter per button
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= '0;
         sync2_r <= '0;
         for (int f = 0; f < NUM_FLOORS; f++) begin
            cnt_r[f] <= '0;
         end
      end else begin
         sync1_r <= call_btn;
         sync2_r <= sync1_r;
         for (int f = 0; f < NUM_FLOORS; f++) begin
            if (!sync2_r[f]) begin
               cnt_r[f] <= '0;
            end else if (cnt_r[f] != CNT_MAX) begin
               cnt_r[f] <= cnt_r[f] + CNT_ONE;
            end else begin
               cnt_r[f] <= cnt_r[f];
            end
         end
      end
   end

   // press fires once, in the cycle the counter steps onto its ceiling; serving beats pressing
   always_comb begin
      press_s       = '0;
      pending_nxt_s = '0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
         press_s[f]       = sync2_r[f] && (cnt_r[f] == (CNT_MAX - CNT_ONE));
         pending_nxt_s[f] = (pending[f] | press_s[f]) & ~(car_idle && (current_floor == 4'(f)));
      end
   end

   // Nearest pending call above and below; with no candidate the target falls back to the car's floor
   always_comb begin
      above_s  = 1'b0;
      below_s  = 1'b0;
      up_tgt_s = current_floor;
      dn_tgt_s = current_floor;
      for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
         above_s  = above_s | (pending[f] && (4'(f) > current_floor));
         up_tgt_s = (pending[f] && (4'(f) > current_floor)) ? 4'(f) : up_tgt_s;
      end
      for (int f = 0; f < NUM_FLOORS; f++) begin
         below_s  = below_s | (pending[f] && (4'(f) < current_floor));
         dn_tgt_s = (pending[f] && (4'(f) < current_floor)) ? 4'(f) : dn_tgt_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt_s;
      end
   end

   // SCAN sweep: keep direction while calls remain ahead, otherwise turn or go idle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         dir_up  <= 1'b1;
         busy    <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (above_s) begin
                  state_r <= S_UP;
                  dir_up  <= 1'b1;
                  busy    <= 1'b1;
               end else if (below_s) begin
                  state_r <= S_DOWN;
                  dir_up  <= 1'b0;
                  busy    <= 1'b1;
               end else begin
                  state_r <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            S_UP: begin
               if (above_s) begin
                  state_r <= S_UP;
                  busy    <= 1'b1;
               end else if (below_s) begin
                  state_r <= S_DOWN;
                  dir_up  <= 1'b0;
                  busy    <= 1'b1;
               end else begin
                  state_r <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            S_DOWN: begin
               if (below_s) begin
                  state_r <= S_DOWN;
                  busy    <= 1'b1;
               end else if (above_s) begin
                  state_r <= S_UP;
                  dir_up  <= 1'b1;
                  busy    <= 1'b1;
               end else begin
                  state_r <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_r <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         requested_floor <= 4'd0;
      end else begin
         case (state_r)
            S_UP:    requested_floor <= up_tgt_s;
            S_DOWN:  requested_floor <= dn_tgt_s;
            S_IDLE:  requested_floor <= current_floor;
            default: requested_floor <= current_floor;
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler: directed scenarios plus randomised traffic
// compared against a floor-level reference model of the scheduling rules.
module tb_elevator_call_scheduler;

   localparam int N = 6;
   localparam int D = 16;
   localparam int M_IDLE = 0;
   localparam int M_UP   = 1;
   localparam int M_DOWN = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] call_btn = '0;
   logic [3:0]   current_floor = 4'd0;
   logic         car_idle = 1'b0;
   logic [3:0]   requested_floor;
   logic [N-1:0] pending;
   logic         dir_up;
   logic         busy;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [N-1:0] m_s1, m_s2, m_pend, m_press;
   int           m_run [N];
   int           m_state;
   bit           m_dir;
   logic [3:0]   m_req;

   elevator_call_scheduler #(.NUM_FLOORS(N), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .call_btn(call_btn), .current_floor(current_floor),
      .car_idle(car_idle), .requested_floor(requested_floor), .pending(pending),
      .dir_up(dir_up), .busy(busy)
   );

   always #5 clk = ~clk;

   // Advance one clock: model evaluates the rules on pre-edge inputs, outputs are sampled #1 after the edge
   task automatic tick();
      logic [N-1:0] press, npend, btn;
      int nrun [N];
      int nstate, cf, up, dn;
      bit ndir, above, below;
      logic [3:0] nreq;
      btn = call_btn;
      cf = int'(current_floor);
      press = '0; npend = '0;
      nstate = m_state; ndir = m_dir;
      if (rst) begin
         for (int f = 0; f < N; f++) nrun[f] = 0;
         nstate = M_IDLE; ndir = 1'b1; nreq = 4'd0;
         btn = '0;
      end else begin
         above = 0; below = 0; up = cf; dn = cf;
         for (int f = 0; f < N; f++) begin
            press[f] = m_s2[f] && (m_run[f] == D - 1);
            nrun[f]  = m_s2[f] ? m_run[f] + 1 : 0;
            npend[f] = (m_pend[f] | press[f]) && !(car_idle && cf == f);
            if (m_pend[f] && f > cf) begin
               if (!above) up = f;
               above = 1;
            end
            if (m_pend[f] && f < cf) begin
               below = 1;
               dn = f;
            end
         end
         if (m_state == M_UP && above) nstate = M_UP;
         else if (m_state == M_DOWN && below) nstate = M_DOWN;
         else if (m_state != M_DOWN && above) begin nstate = M_UP; ndir = 1'b1; end
         else if (below) begin nstate = M_DOWN; ndir = 1'b0; end
         else if (above) begin nstate = M_UP; ndir = 1'b1; end
         else nstate = M_IDLE;
         nreq = (m_state == M_UP) ? 4'(up) : (m_state == M_DOWN) ? 4'(dn) : current_floor;
      end
      @(posedge clk);
      #1;
      m_s2 = rst ? '0 : m_s1;
      m_s1 = btn;
      for (int f = 0; f < N; f++) m_run[f] = nrun[f];
      m_press = press;
      m_pend = npend;
      m_state = nstate;
      m_dir = ndir;
      m_req = nreq;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; call_btn = '0;
      ticks(2);
      rst = 1'b0;
      ticks(3);
   endtask

   task automatic test_reset();
      rst = 1'b1; call_btn = '1; current_floor = 4'd0; car_idle = 1'b0;
      ticks(40);
      checks++; if (pending !== 6'b000000) begin errors++; $display("FAIL reset_pending got %b exp 000000", pending); end
      checks++; if (requested_floor !== 4'd0) begin errors++; $display("FAIL reset_req got %0d exp 0", requested_floor); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir got %b exp 1", dir_up); end
      rst = 1'b0; call_btn = '0;
      ticks(4);
   endtask

   task automatic test_single_call();
      int first_pend, first_req;
      first_pend = -1; first_req = -1;
      current_floor = 4'd0; car_idle = 1'b1; call_btn = 6'b001000;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (first_pend < 0 && pending[3] === 1'b1) first_pend = i;
         if (first_req < 0 && requested_floor === 4'd3) first_req = i;
         checks++; if (pending !== m_pend) begin errors++; $display("FAIL single_pending_model got %b exp %b", pending, m_pend); end
      end
      checks++; if (first_pend != D + 2) begin errors++; $display("FAIL single_pend_latency got %0d exp %0d", first_pend, D + 2); end
      checks++; if (first_req != D + 4) begin errors++; $display("FAIL single_req_latency got %0d exp %0d", first_req, D + 4); end
      checks++; if (pending !== 6'b001000) begin errors++; $display("FAIL single_pending got %b exp 001000", pending); end
      checks++; if (busy !== 1'b1 || dir_up !== 1'b1) begin errors++; $display("FAIL single_up got busy %b dir %b exp 1 1", busy, dir_up); end
      checks++; if (requested_floor !== 4'd3) begin errors++; $display("FAIL single_req got %0d exp 3", requested_floor); end
      call_btn = '0; current_floor = 4'd3; car_idle = 1'b1;
      tick();
      checks++; if (pending[3] !== 1'b0) begin errors++; $display("FAIL single_serve got %b exp 0", pending[3]); end
      ticks(2);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", busy); end
      checks++; if (requested_floor !== 4'd3) begin errors++; $display("FAIL single_stay got %0d exp 3", requested_floor); end
   endtask

   task automatic test_debounce();
      int seen;
      seen = 0;
      call_btn = 6'b010000;
      ticks(D - 2);
      call_btn = '0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (pending !== 6'b000000 || busy !== 1'b0) seen = 1;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL debounce_short got pending %b busy %b exp 0 0", pending, busy); end
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL debounce_model got %b exp %b", pending, m_pend); end
   endtask

   task automatic test_scan();
      current_floor = 4'd2; car_idle = 1'b0; call_btn = 6'b010010;
      ticks(20);
      call_btn = '0;
      ticks(4);
      checks++; if (requested_floor !== 4'd4) begin errors++; $display("FAIL scan_up_req got %0d exp 4", requested_floor); end
      checks++; if (dir_up !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL scan_up_state got dir %b busy %b exp 1 1", dir_up, busy); end
      current_floor = 4'd4; car_idle = 1'b1;
      ticks(5);
      checks++; if (pending !== 6'b000010) begin errors++; $display("FAIL scan_served got %b exp 000010", pending); end
      checks++; if (dir_up !== 1'b0) begin errors++; $display("FAIL scan_turn_dir got %b exp 0", dir_up); end
      checks++; if (requested_floor !== 4'd1) begin errors++; $display("FAIL scan_down_req got %0d exp 1", requested_floor); end
   endtask

   task automatic test_intercept();
      int press_at, req_at;
      press_at = -1; req_at = -1;
      do_reset();
      current_floor = 4'd0; car_idle = 1'b0; call_btn = 6'b100000;
      ticks(20);
      call_btn = '0;
      ticks(4);
      checks++; if (requested_floor !== 4'd5) begin errors++; $display("FAIL intercept_far got %0d exp 5", requested_floor); end
      current_floor = 4'd1; call_btn = 6'b000100;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (press_at < 0 && m_press[2]) press_at = i;
         if (press_at >= 0 && req_at < 0 && requested_floor === 4'd2) req_at = i;
      end
      call_btn = '0;
      checks++;
      if (press_at < 0 || req_at < 0 || req_at - press_at > 3) begin
         errors++; $display("FAIL intercept_latency got press %0d req %0d exp within 3", press_at, req_at);
      end
   endtask

   task automatic test_collisions();
      int leaked;
      leaked = 0;
      do_reset();
      current_floor = 4'd2; car_idle = 1'b1; call_btn = 6'b000100;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (pending[2] !== 1'b0) leaked = 1;
      end
      call_btn = '0;
      checks++; if (leaked != 0) begin errors++; $display("FAIL collide_at_floor got pending %b exp 0", pending); end
      current_floor = 4'd5; car_idle = 1'b0; call_btn = 6'b001011;
      ticks(20);
      call_btn = '0;
      ticks(4);
      checks++; if (busy !== 1'b1 || dir_up !== 1'b0) begin errors++; $display("FAIL collide_down got busy %b dir %b exp 1 0", busy, dir_up); end
      checks++; if (pending !== 6'b001011) begin errors++; $display("FAIL collide_calls got %b exp 001011", pending); end
      rst = 1'b1;
      tick();
      checks++;
      if (pending !== 6'b0 || requested_floor !== 4'd0 || busy !== 1'b0 || dir_up !== 1'b1) begin
         errors++; $display("FAIL collide_reset got p %b r %0d b %b d %b exp 0 0 0 1", pending, requested_floor, busy, dir_up);
      end
      rst = 1'b0;
      ticks(3);
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         for (int f = 0; f < N; f++) begin
            if ($urandom_range(0, 24) == 0) call_btn[f] = ~call_btn[f];
         end
         if ($urandom_range(0, 29) == 0) current_floor = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) car_idle = ~car_idle;
         rst = ($urandom_range(0, 499) == 0);
         tick();
         checks++; if (pending !== m_pend) begin errors++; $display("FAIL rand_pending cyc %0d got %b exp %b", i, pending, m_pend); end
         checks++; if (requested_floor !== m_req) begin errors++; $display("FAIL rand_req cyc %0d got %0d exp %0d", i, requested_floor, m_req); end
         checks++; if (busy !== (m_state != M_IDLE)) begin errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", i, busy, m_state != M_IDLE); end
         checks++; if (dir_up !== m_dir) begin errors++; $display("FAIL rand_dir cyc %0d got %b exp %b", i, dir_up, m_dir); end
      end
      rst = 1'b0;
   endtask

   initial begin
      m_s1 = '0; m_s2 = '0; m_pend = '0; m_press = '0;
      for (int f = 0; f < N; f++) m_run[f] = 0;
      m_state = M_IDLE; m_dir = 1'b1; m_req = 4'd0;
      test_reset();
      test_single_call();
      test_debounce();
      test_scan();
      test_intercept();
      test_collisions();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
